pfb_reload_stream_gen: RTL and testbench

- Source end of the PFB coefficient reload AXI-Stream. Its output feeds the reload slave of the PFB memory controller.
- Host software loads up to 2^ADDR_W coefficients into a local staging RAM through a simple write port.
- A start pulse then streams entries 0..len_m1 as a single AXIS packet, with tlast on the final word.
- Full backpressure support; sustains one word per clock while tready is high.

---
 rtl/pfb_reload_stream_gen.sv | 132 +++++++++++++
 tb/tb_pfb_reload_stream_gen.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pfb_reload_stream_gen.sv
// Streams staged PFB coefficients out as one AXI-Stream packet for the memory controller reload port.
// Host fills the staging RAM while idle; a start pulse sends entries 0..len_m1 with tlast on the final word.
module pfb_reload_stream_gen #(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned COEF_W = 25
) (
   input  logic              clk,
   input  logic              sync_reset,
   input  logic              cfg_wr_en,
   input  logic [ADDR_W-1:0] cfg_wr_addr,
   input  logic [COEF_W-1:0] cfg_wr_data,
   input  logic [ADDR_W-1:0] cfg_len_m1,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              cfg_wr_err,
   output logic              m_axis_reload_tvalid,
   output logic [31:0]       m_axis_reload_tdata,
   output logic              m_axis_reload_tlast,
   input  logic              m_axis_reload_tready
);

   localparam int unsigned DEPTH = 1 << ADDR_W;
   localparam int unsigned PTR_W = ADDR_W + 1;

   typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;

   state_t              state_q, state_d;
   logic [COEF_W-1:0]   ram [DEPTH];
   logic [COEF_W-1:0]   rd_coef;
   logic [PTR_W-1:0]    rd_ptr;
   logic [ADDR_W-1:0]   len_q;
   logic                rd_vld;
   logic                rd_last;
   logic                sp_valid;
   logic [31:0]         sp_data;
   logic                sp_last;

   logic                start_ok_c;
   logic                wr_ok_c;
   logic                pop_c;
   logic                last_pop_c;
   logic                issue_c;
   logic [2:0]          occ_c;
   logic [31:0]         rd_word_c;

   assign start_ok_c = (state_q == IDLE) && start;
   assign wr_ok_c    = (state_q == IDLE) && cfg_wr_en;
   assign pop_c      = m_axis_reload_tvalid && m_axis_reload_tready;
   assign last_pop_c = pop_c && m_axis_reload_tlast;

   // Occupancy after this cycle's pop; a read is launched only if its word is guaranteed a skid slot.
   assign occ_c   = 3'(rd_vld) + 3'(m_axis_reload_tvalid) + 3'(sp_valid) - 3'(pop_c);
   assign issue_c = (state_q == STREAM) && (occ_c < 3'd2) && (rd_ptr <= PTR_W'(len_q));

   assign rd_word_c = {{(32-COEF_W){rd_coef[COEF_W-1]}}, rd_coef};

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = STREAM;
         STREAM:  if (last_pop_c) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Staging RAM; writes and reads live in different states, so no collision handling is needed
   always_ff @(posedge clk) begin
      if (wr_ok_c) ram[cfg_wr_addr] <= cfg_wr_data;
      if (issue_c) rd_coef <= ram[rd_ptr[ADDR_W-1:0]];
   end

   always_ff @(posedge clk) begin
      if (sync_reset) begin
         state_q              <= IDLE;
         busy                 <= 1'b0;
         done                 <= 1'b0;
         cfg_wr_err           <= 1'b0;
         len_q                <= '0;
         rd_ptr               <= '0;
         rd_vld               <= 1'b0;
         rd_last              <= 1'b0;
         sp_valid             <= 1'b0;
         sp_data              <= '0;
         sp_last              <= 1'b0;
         m_axis_reload_tvalid <= 1'b0;
         m_axis_reload_tdata  <= '0;
         m_axis_reload_tlast  <= 1'b0;
      end else begin
         state_q    <= state_d;
         busy       <= (state_d == STREAM);
         done       <= last_pop_c;
         cfg_wr_err <= cfg_wr_en && (state_q != IDLE);

         if (start_ok_c) begin
            len_q  <= cfg_len_m1;
            rd_ptr <= '0;
         end else if (issue_c) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end

         rd_vld <= issue_c;
         if (issue_c) rd_last <= (rd_ptr == PTR_W'(len_q));

         // Two-slot skid: output register is the head, sp_* is the overflow slot
         if (!m_axis_reload_tvalid || pop_c) begin
            if (sp_valid) begin
               m_axis_reload_tvalid <= 1'b1;
               m_axis_reload_tdata  <= sp_data;
               m_axis_reload_tlast  <= sp_last;
               sp_valid             <= rd_vld;
               if (rd_vld) begin
                  sp_data <= rd_word_c;
                  sp_last <= rd_last;
               end
            end else begin
               m_axis_reload_tvalid <= rd_vld;
               if (rd_vld) begin
                  m_axis_reload_tdata <= rd_word_c;
                  m_axis_reload_tlast <= rd_last;
               end
            end
         end else if (rd_vld) begin
            sp_valid <= 1'b1;
            sp_data  <= rd_word_c;
            sp_last  <= rd_last;
         end
      end
   end

endmodule

// File: tb/tb_pfb_reload_stream_gen.sv
// Scoreboard bench for pfb_reload_stream_gen: stimulus pushes expected beats, a negedge monitor pops and compares.
module tb_pfb_reload_stream_gen;

   localparam int unsigned AW = 10;
   localparam int unsigned CW = 25;

   typedef struct packed {
      logic [31:0] data;
      logic        last;
   } beat_t;

   logic          clk = 1'b0;
   logic          sync_reset;
   logic          cfg_wr_en;
   logic [AW-1:0] cfg_wr_addr;
   logic [CW-1:0] cfg_wr_data;
   logic [AW-1:0] cfg_len_m1;
   logic          start;
   logic          busy;
   logic          done;
   logic          cfg_wr_err;
   logic          tvalid;
   logic [31:0]   tdata;
   logic          tlast;
   logic          tready;

   beat_t         exp_q[$];
   beat_t         e;
   logic [CW-1:0] mem_model [1 << AW];
   int            total = 0;
   int            bad = 0;
   int            tlast_seen = 0;
   int            tready_mode = 0;
   int            pidx = 0;
   logic          pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
   logic          pv = 1'b0;
   logic          pr = 1'b0;
   logic          prst = 1'b1;

   pfb_reload_stream_gen #(.ADDR_W(AW), .COEF_W(CW)) dut (
      .clk                  (clk),
      .sync_reset           (sync_reset),
      .cfg_wr_en            (cfg_wr_en),
      .cfg_wr_addr          (cfg_wr_addr),
      .cfg_wr_data          (cfg_wr_data),
      .cfg_len_m1           (cfg_len_m1),
      .start                (start),
      .busy                 (busy),
      .done                 (done),
      .cfg_wr_err           (cfg_wr_err),
      .m_axis_reload_tvalid (tvalid),
      .m_axis_reload_tdata  (tdata),
      .m_axis_reload_tlast  (tlast),
      .m_axis_reload_tready (tready)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] sext(input logic [CW-1:0] c);
      return {{(32-CW){c[CW-1]}}, c};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%h want=%h", name, act, exp);
      end
   endtask

   // Monitor: squashed handshakes (reset sampled at the same edge) are not real beats
   always @(negedge clk) begin
      if (!prst && pv && !pr) begin
         check("hold_valid", 32'(tvalid), 32'd1);
         if (exp_q.size() > 0) begin
            check("hold_data", tdata, exp_q[0].data);
            check("hold_last", 32'(tlast), 32'(exp_q[0].last));
         end
      end
      if (!sync_reset && tvalid && tready) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_beat: got=%h want=none", tdata);
         end else begin
            e = exp_q.pop_front();
            check("beat_data", tdata, e.data);
            check("beat_last", 32'(tlast), 32'(e.last));
         end
         if (tlast) tlast_seen++;
      end
      pv   = tvalid;
      pr   = tready;
      prst = sync_reset;
   end

   // Downstream ready pattern generator
   initial begin
      tready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (tready_mode)
            1: begin
               tready = pat[pidx];
               pidx   = (pidx + 1) % 6;
            end
            2:       tready = ~tready;
            default: tready = 1'b1;
         endcase
      end
   end

   task automatic cfg_write(input int a, input logic [CW-1:0] d);
      cfg_wr_en   = 1'b1;
      cfg_wr_addr = AW'(a);
      cfg_wr_data = d;
      mem_model[a] = d;
      @(posedge clk);
      #1;
      cfg_wr_en = 1'b0;
   endtask

   task automatic push_model(input int len);
      for (int i = 0; i <= len; i++) exp_q.push_back('{data: sext(mem_model[i]), last: (i == len)});
   endtask

   task automatic start_pkt(input int len);
      cfg_len_m1 = AW'(len);
      start      = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      check("busy_on_start", 32'(busy), 32'd1);
      check("lat_valid_n0", 32'(tvalid), 32'd0);
      @(posedge clk);
      #1;
      check("lat_valid_n1", 32'(tvalid), 32'd0);
      @(posedge clk);
      #1;
      check("lat_valid_n2", 32'(tvalid), 32'd1);
   endtask

   task automatic wait_done(input int budget, output int cyc);
      cyc = 0;
      while (!done && cyc < budget) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      check("done_seen", 32'(done), 32'd1);
      @(posedge clk);
      #1;
      check("done_one_cycle", 32'(done), 32'd0);
      check("busy_after_done", 32'(busy), 32'd0);
   endtask

   int cyc;
   int t0;

   initial begin
      sync_reset  = 1'b1;
      cfg_wr_en   = 1'b0;
      cfg_wr_addr = '0;
      cfg_wr_data = '0;
      cfg_len_m1  = '0;
      start       = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_tvalid", 32'(tvalid), 32'd0);
      check("rst_tdata", tdata, 32'd0);
      check("rst_tlast", 32'(tlast), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_wr_err", 32'(cfg_wr_err), 32'd0);
      sync_reset = 1'b0;

      // 16-word packet, addr i holds i-8, full-rate
      for (int i = 0; i < 16; i++) cfg_write(i, CW'(i - 8));
      for (int i = 0; i < 16; i++) exp_q.push_back('{data: 32'hFFFF_FFF8 + 32'(i), last: (i == 15)});
      start_pkt(15);
      wait_done(100, cyc);
      check("pkt16_cycles", 32'(cyc), 32'd16);
      check("pkt16_drained", 32'(exp_q.size()), 32'd0);

      // Same packet under a stuttering ready
      tready_mode = 1;
      for (int i = 0; i < 16; i++) exp_q.push_back('{data: 32'hFFFF_FFF8 + 32'(i), last: (i == 15)});
      start_pkt(15);
      wait_done(200, cyc);
      check("stall_drained", 32'(exp_q.size()), 32'd0);
      tready_mode = 0;
      @(posedge clk);
      #1;

      // Single-word packets at the sign boundary
      cfg_write(0, 25'h0FF_FFFF);
      exp_q.push_back('{data: 32'h00FF_FFFF, last: 1'b1});
      start_pkt(0);
      wait_done(20, cyc);
      check("one_pos_cycles", 32'(cyc), 32'd1);
      cfg_write(0, 25'h100_0000);
      exp_q.push_back('{data: 32'hFF00_0000, last: 1'b1});
      start_pkt(0);
      wait_done(20, cyc);
      check("one_neg_cycles", 32'(cyc), 32'd1);

      // 100-word packet with dropped write and ignored start while busy, toggling ready
      for (int i = 0; i < 100; i++) cfg_write(i, CW'(i * 1000 - 30000));
      push_model(99);
      tready_mode = 2;
      t0 = tlast_seen;
      start_pkt(99);
      cfg_wr_en   = 1'b1;
      cfg_wr_addr = AW'(50);
      cfg_wr_data = 25'h0AB_CDEF;
      cfg_len_m1  = AW'(5);
      start       = 1'b1;
      @(posedge clk);
      #1;
      cfg_wr_en = 1'b0;
      start     = 1'b0;
      check("wr_err_pulse", 32'(cfg_wr_err), 32'd1);
      check("busy_during", 32'(busy), 32'd1);
      @(posedge clk);
      #1;
      check("wr_err_clear", 32'(cfg_wr_err), 32'd0);
      wait_done(400, cyc);
      repeat (10) @(posedge clk);
      #1;
      check("one_tlast", 32'(tlast_seen - t0), 32'd1);
      check("no_restart_busy", 32'(busy), 32'd0);
      check("no_restart_valid", 32'(tvalid), 32'd0);
      check("p100_drained", 32'(exp_q.size()), 32'd0);
      tready_mode = 0;
      @(posedge clk);
      #1;

      // Full depth, no wrap, no bubbles
      for (int i = 0; i < (1 << AW); i++) cfg_write(i, CW'(i * 32'h009E_3779));
      push_model((1 << AW) - 1);
      t0 = tlast_seen;
      start_pkt((1 << AW) - 1);
      wait_done((1 << AW) + 50, cyc);
      check("full_cycles", 32'(cyc), 32'(1 << AW));
      check("full_one_tlast", 32'(tlast_seen - t0), 32'd1);
      check("full_drained", 32'(exp_q.size()), 32'd0);

      // Reset while beat 7 is presented, then replay
      for (int i = 0; i < 7; i++) exp_q.push_back('{data: sext(mem_model[i]), last: 1'b0});
      start_pkt(15);
      repeat (7) begin
         @(posedge clk);
         #1;
      end
      sync_reset = 1'b1;
      @(posedge clk);
      #1;
      sync_reset = 1'b0;
      check("rst_mid_valid", 32'(tvalid), 32'd0);
      check("rst_mid_busy", 32'(busy), 32'd0);
      check("rst_mid_last", 32'(tlast), 32'd0);
      check("rst_mid_beats", 32'(exp_q.size()), 32'd0);
      push_model(15);
      start_pkt(15);
      wait_done(100, cyc);
      check("replay_cycles", 32'(cyc), 32'd16);
      check("replay_drained", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got=timeout want=finish");
      $fatal(1, "watchdog");
   end

endmodule
